axi_lite_reg_bank: RTL
======================

Name: axi_lite_reg_bank

Overview:
Parametrised AXI4-Lite slave register bank; successor to the fixed 12-bit, prefix-decoded register slave.
- Generalised: register count, address window and prefix.
- New: per-register read-only mask, reset values and honoured WSTRB byte enables.
- New: SLVERR on decode miss, independent AW/W acceptance, per-register write/read strobes.
- Sits between the shell AXI-Lite interconnect and a user block's control/status registers.

Parameters:
REG_ADDR_W, 12, byte-address bits decoded inside the window; addr[REG_ADDR_W-1:2] is the register index.
REG_PREFIX, 32'h0000_0000, window base; hit when addr[31:REG_ADDR_W] == REG_PREFIX[31:REG_ADDR_W].
NUM_REGS, 16, implemented 32-bit registers, 1..2^(REG_ADDR_W-2).
RO_MASK, {NUM_REGS{1'b0}}, bit i=1: register i is read-only, reads return reg_in[i].
RST_VAL, {NUM_REGS*32{1'b0}}, flattened reset value of each RW register.

Ports:
aclk  in  1  clock.
aresetn  in  1  reset; asynchronous assert, active-low.
s_axil_awvalid/awready  in/out  1/1  write-address handshake.
s_axil_awaddr  in  32  write byte address.
s_axil_wvalid/wready  in/out  1/1  write-data handshake.
s_axil_wdata  in  32  write data.
s_axil_wstrb  in  4  byte enables, honoured.
s_axil_bvalid/bready  out/in  1/1  write-response handshake.
s_axil_bresp  out  2  write response.
s_axil_arvalid/arready  in/out  1/1  read-address handshake.
s_axil_araddr  in  32  read byte address.
s_axil_rvalid/rready  out/in  1/1  read-data handshake.
s_axil_rdata  out  32  read data.
s_axil_rresp  out  2  read response.
reg_out  out  NUM_REGS*32  current RW register values; RO slots drive 0.
reg_in  in  NUM_REGS*32  status values for RO registers.
wr_pulse  out  NUM_REGS  one-cycle pulse, cycle after an accepted write commits to reg i.
rd_pulse  out  NUM_REGS  one-cycle pulse, cycle after read data for reg i is latched (clear-on-read hook).

Behaviour:
- Reset (aresetn=0, async) drives:
  - awready, wready, arready, bvalid, rvalid = 0.
  - bresp, rresp = 2'b00; rdata = 0.
  - reg_out = RST_VAL; pulses = 0.
  - Any in-flight transaction is dropped; no response is issued for it.
- awready, wready and arready rise on the first aclk edge after reset release.
- Write FSM, states W_IDLE / W_RESP:
  - W_IDLE: awready=1 until an AW beat is captured; wready=1 until a W beat is captured. AW and W may arrive in any order or in the same cycle.
  - Once both are captured, the write commits on the next edge: masked byte update (byte b written iff wstrb[b]), bvalid=1, wr_pulse[i]=1 for one cycle, state -> W_RESP.
  - A write latency of 1 cycle after the later of AW/W is required.
  - W_RESP: awready=wready=0; hold bvalid/bresp until bready. On bvalid&&bready return to W_IDLE; ready signals rise the following cycle.
- Read FSM, states R_IDLE / R_DATA:
  - R_IDLE: arready=1. On arvalid&&arready, rdata/rresp are latched on that same edge, rvalid=1, state -> R_DATA, rd_pulse[i] next cycle.
  - R_DATA: arready=0; hold rdata/rresp/rvalid until rready, then return to R_IDLE.
- Decode (both channels):
  - Prefix mismatch or index >= NUM_REGS -> SLVERR (2'b10). Write discarded, no wr_pulse; read returns rdata=0, no rd_pulse.
  - Write to an RO register -> SLVERR, no state change.
  - Otherwise OKAY (2'b00).
  - addr[1:0] is ignored.
- wstrb=4'b0000 to a valid RW register -> OKAY, value unchanged, wr_pulse still fires.
- Simultaneous read capture and write commit to the same register: read returns the pre-write value.
- Read and write channels are fully independent; at most one outstanding transaction per channel.

Decomposition:
- Package axil_pkg:
  - Response localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Enums wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
  - Function strb_merge(old, data, strb).
- One sub-module, axi_lite_addr_decode: combinational address -> {hit, index, is_ro}. Instantiated once for AW and once for AR.

Test Plan:
- Reset release with NUM_REGS=4, RST_VAL reg2=32'hCAFE_0001 -> reg_out[2]=32'hCAFE_0001; arready=1 after first edge; read 0x008 -> rdata 32'hCAFE_0001, rresp 00.
- W beat (32'h1122_3344, wstrb 4'b0101) presented 3 cycles before AW 0x004, reg1 previously 0 -> bvalid 1 cycle after AW accept, bresp 00, reg_out[1]=32'h0022_0044, wr_pulse[1] high exactly one cycle.
- Write 0x040 (index 16 >= NUM_REGS=16) and read 0x040 -> bresp 10, rresp 10, rdata 0, no pulses, all registers unchanged.
- RO_MASK bit3=1, reg_in[3]=32'hDEAD_BEEF -> read 0x00C returns 32'hDEAD_BEEF with rd_pulse[3]; write 0x00C -> bresp 10, reg_out[3] stays 0.
- bready held low 10 cycles -> bvalid/bresp stable, awready=wready=0 throughout; an AR issued meanwhile completes normally.
- aresetn pulled low while rvalid=1 awaiting rready -> rvalid=0 immediately (async), reg_out returns to RST_VAL; after release no stale response appears.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank: response codes,
// channel FSM states and the byte-enable merge used on write commit.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Byte b of the result comes from data when strb[b] is set, else from old_val.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational byte-address decode for the register window: prefix match,
// register index, range check and read-only lookup.
module axi_lite_addr_decode
  import axil_pkg::*;
#(
  parameter int                  REG_ADDR_W = 12,
  parameter logic [31:0]         REG_PREFIX = 32'h0000_0000,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic [31:0]           i_addr,
  output logic                  o_hit,
  output logic [REG_ADDR_W-3:0] o_index,
  output logic                  o_is_ro
);

  localparam int IDX_W = REG_ADDR_W - 2;

  logic w_prefix_hit;
  logic w_in_range;
  logic w_unused_lsb;

  // Byte lanes within a word carry no decode information.
  assign w_unused_lsb = ^i_addr[1:0];

  assign o_index      = i_addr[REG_ADDR_W-1:2];
  assign w_prefix_hit = (i_addr[31:REG_ADDR_W] == REG_PREFIX[31:REG_ADDR_W]);
  assign w_in_range   = ({{(32-IDX_W){1'b0}}, o_index} < 32'(NUM_REGS));
  assign o_hit        = w_prefix_hit && w_in_range;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    o_is_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (o_index == IDX_W'(i)) o_is_ro = RO_MASK[i];
    end
    o_is_ro = o_is_ro && o_hit;
  end

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank with parametrised window, read-only status
// slots, byte-enable writes, SLVERR on decode miss and per-register strobes.
module axi_lite_reg_bank
  import axil_pkg::*;
#(
  parameter int                     REG_ADDR_W = 12,
  parameter logic [31:0]            REG_PREFIX = 32'h0000_0000,
  parameter int                     NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
  parameter logic [NUM_REGS*32-1:0] RST_VAL    = '0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [31:0]              s_axil_awaddr,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  input  logic [31:0]              s_axil_wdata,
  input  logic [3:0]               s_axil_wstrb,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  output logic [1:0]               s_axil_bresp,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  input  logic [31:0]              s_axil_araddr,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic [NUM_REGS*32-1:0]   reg_out,
  input  logic [NUM_REGS*32-1:0]   reg_in,
  output logic [NUM_REGS-1:0]      wr_pulse,
  output logic [NUM_REGS-1:0]      rd_pulse
);

  localparam int IDX_W = REG_ADDR_W - 2;

  wr_state_t   r_wr_state;
  rd_state_t   r_rd_state;
  logic [31:0] r_regs [NUM_REGS];
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  logic             w_aw_hit;
  logic [IDX_W-1:0] w_aw_idx;
  logic             w_aw_ro;
  logic             w_aw_ok;
  logic             w_ar_hit;
  logic [IDX_W-1:0] w_ar_idx;
  logic             w_unused_ar_ro;
  logic [31:0]      w_rd_data;

  axi_lite_addr_decode #(
    .REG_ADDR_W (REG_ADDR_W),
    .REG_PREFIX (REG_PREFIX),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_aw_decode (
    .i_addr  (r_awaddr),
    .o_hit   (w_aw_hit),
    .o_index (w_aw_idx),
    .o_is_ro (w_aw_ro)
  );

  axi_lite_addr_decode #(
    .REG_ADDR_W (REG_ADDR_W),
    .REG_PREFIX (REG_PREFIX),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_ar_decode (
    .i_addr  (s_axil_araddr),
    .o_hit   (w_ar_hit),
    .o_index (w_ar_idx),
    .o_is_ro (w_unused_ar_ro)
  );

  assign w_aw_ok = w_aw_hit && !w_aw_ro;

  // Read-only slots expose the live status input; RW slots the stored value.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == IDX_W'(i)) begin
        w_rd_data = RO_MASK[i] ? reg_in[i*32 +: 32] : r_regs[i];
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*32 +: 32] = RO_MASK[i] ? 32'h0 : r_regs[i];
    end
  end

  // Write channel: AW and W are captured independently; the commit happens on
  // the edge after both are held, so latency is one cycle after the later beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_state     <= W_IDLE;
      r_aw_done      <= 1'b0;
      r_w_done       <= 1'b0;
      r_awaddr       <= '0;
      r_wdata        <= '0;
      r_wstrb        <= '0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
      wr_pulse       <= '0;
      // NOTE: the register array is built from flops, not RAM, so it takes
      // its reset value here like any other state.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RO_MASK[i] ? 32'h0 : RST_VAL[i*32 +: 32];
      end
    end else begin
      wr_pulse <= '0;
      unique case (r_wr_state)
        W_IDLE: begin
          if (r_aw_done && r_w_done) begin
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (w_aw_ok && (w_aw_idx == IDX_W'(i))) begin
                r_regs[i]   <= strb_merge(r_regs[i], r_wdata, r_wstrb);
                wr_pulse[i] <= 1'b1;
              end
            end
            r_wr_state <= W_RESP;
          end else begin
            if (s_axil_awvalid && s_axil_awready) begin
              r_awaddr       <= s_axil_awaddr;
              r_aw_done      <= 1'b1;
              s_axil_awready <= 1'b0;
            end else if (!r_aw_done) begin
              s_axil_awready <= 1'b1;
            end
            if (s_axil_wvalid && s_axil_wready) begin
              r_wdata       <= s_axil_wdata;
              r_wstrb       <= s_axil_wstrb;
              r_w_done      <= 1'b1;
              s_axil_wready <= 1'b0;
            end else if (!r_w_done) begin
              s_axil_wready <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axil_bvalid && s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_wr_state    <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read channel: data is sampled on the AR handshake edge, so a write
  // committing on that same edge is not yet visible to the read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_state     <= R_IDLE;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= RESP_OKAY;
      rd_pulse       <= '0;
    end else begin
      rd_pulse <= '0;
      unique case (r_rd_state)
        R_IDLE: begin
          if (s_axil_arvalid && s_axil_arready) begin
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b1;
            s_axil_rdata   <= w_ar_hit ? w_rd_data : 32'h0;
            s_axil_rresp   <= w_ar_hit ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (w_ar_hit && (w_ar_idx == IDX_W'(i))) rd_pulse[i] <= 1'b1;
            end
            r_rd_state <= R_DATA;
          end else begin
            s_axil_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axil_rvalid && s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
            r_rd_state    <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule
